// File: rtl/spi_sub.sv
// ============================================================================
// spi_sub -- SPI subordinate endpoint on the AES core side of the link.
//
// Receives one frame per cs_n-low interval: a 2-bit length header followed by
// a 128/192/256-bit payload, MSB first. While the frame is received, the
// 128-bit result word held for the AES core is shifted out on miso during the
// first 128 bit-times. All SPI inputs are oversampled on the local clock.
//
// Data phase: mosi is sampled on synchronized sclk falls. miso changes on
// synchronized sclk rises, so the main can capture it on its falling edge.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   sclk        SPI clock from the main, idles low
//   cs_n        chip select, active low
//   mosi        serial data from the main
//   miso        serial data to the main
//   tx_data     128-bit result word from the AES core
//   tx_load     one-cycle strobe capturing tx_data into the holding register
//   rx_mode     header of the last good frame
//   rx_payload  payload of the last good frame, right-aligned, zero-extended
//   rx_valid    one-cycle pulse when a good frame completes
//   frame_err   one-cycle pulse when a bad frame completes
//   busy        high while a frame is active
// ============================================================================
module spi_sub #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [127:0] tx_data,
    input  logic         tx_load,
    output logic [1:0]   rx_mode,
    output logic [255:0] rx_payload,
    output logic         rx_valid,
    output logic         frame_err,
    output logic         busy
);

    localparam logic [8:0] CNT_MAX = 9'd259;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,    cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q,  mosi_sync_d;
    logic                   sclk_prev_q,  sclk_prev_d;
    logic                   cs_prev_q,    cs_prev_d;
    logic                   started_q,    started_d;
    logic                   armed_q,      armed_d;
    logic [127:0]           holding_q,    holding_d;
    logic [127:0]           tx_sh_q,      tx_sh_d;
    logic [257:0]           rx_sh_q,      rx_sh_d;
    logic [1:0]             hdr_q,        hdr_d;
    logic [8:0]             cnt_q,        cnt_d;
    logic                   miso_q,       miso_d;
    logic [1:0]             rx_mode_q,    rx_mode_d;
    logic [255:0]           rx_payload_q, rx_payload_d;
    logic                   rx_valid_q,   rx_valid_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Synchronized views and edge pulses
    // ------------------------------------------------------------------
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    // A cs_n fall only counts once cs_n has been seen high after reset, so a
    // reset released in the middle of a frame does not start a partial frame.
    assign cs_fall   = ~cs_s   &  cs_prev_q & armed_q;

    // ------------------------------------------------------------------
    // Frame check helpers
    // ------------------------------------------------------------------
    logic [8:0]   exp_total;
    logic         frame_good;
    logic [255:0] payload_sel;

    always_comb begin
        exp_total   = 9'd0;
        payload_sel = '0;
        unique case (hdr_q)
            2'b00: begin
                exp_total   = 9'd130;
                payload_sel = {128'd0, rx_sh_q[127:0]};
            end
            2'b01: begin
                exp_total   = 9'd194;
                payload_sel = {64'd0, rx_sh_q[191:0]};
            end
            2'b10: begin
                exp_total   = 9'd258;
                payload_sel = rx_sh_q[255:0];
            end
            default: begin
                exp_total   = 9'd0;
                payload_sel = '0;
            end
        endcase
        frame_good = (hdr_q != 2'b11) && (cnt_q == exp_total);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d  = sclk_s;
        cs_prev_d    = cs_s;
        started_d    = 1'b1;
        // First stage reflects the pin one cycle after reset release.
        armed_d      = armed_q | (started_q & cs_sync_q[0]);

        state_d      = state_q;
        holding_d    = tx_load ? tx_data : holding_q;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        hdr_d        = hdr_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        rx_mode_d    = rx_mode_q;
        rx_payload_d = rx_payload_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        unique case (state_q)
            ST_IDLE, ST_CHECK: begin
                if (state_q == ST_CHECK) begin
                    if (frame_good) begin
                        rx_mode_d    = hdr_q;
                        rx_payload_d = payload_sel;
                        rx_valid_d   = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
                if (cs_fall) begin
                    // Snapshot the holding register so later loads only
                    // affect the next frame.
                    state_d = ST_ACTIVE;
                    tx_sh_d = holding_q;
                    rx_sh_d = '0;
                    hdr_d   = 2'b00;
                    cnt_d   = 9'd0;
                    miso_d  = holding_q[127];
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            ST_ACTIVE: begin
                busy_d = 1'b1;
                if (cs_rise) begin
                    // End of frame wins over any coincident sclk edge.
                    state_d = ST_CHECK;
                    busy_d  = 1'b0;
                    miso_d  = 1'b0;
                end else if (sclk_fall) begin
                    rx_sh_d = {rx_sh_q[256:0], mosi_s};
                    if (cnt_q == 9'd0) hdr_d[1] = mosi_s;
                    if (cnt_q == 9'd1) hdr_d[0] = mosi_s;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 9'd1;
                end else if (sclk_rise) begin
                    if (cnt_q >= 9'd128) begin
                        miso_d = 1'b0;
                    end else if (cnt_q != 9'd0) begin
                        tx_sh_d = {tx_sh_q[126:0], 1'b0};
                        miso_d  = tx_sh_q[126];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            started_q    <= 1'b0;
            armed_q      <= 1'b0;
            holding_q    <= '0;
            tx_sh_q      <= '0;
            rx_sh_q      <= '0;
            hdr_q        <= 2'b00;
            cnt_q        <= 9'd0;
            miso_q       <= 1'b0;
            rx_mode_q    <= 2'b00;
            rx_payload_q <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            started_q    <= started_d;
            armed_q      <= armed_d;
            holding_q    <= holding_d;
            tx_sh_q      <= tx_sh_d;
            rx_sh_q      <= rx_sh_d;
            hdr_q        <= hdr_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            rx_mode_q    <= rx_mode_d;
            rx_payload_q <= rx_payload_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign miso       = miso_q;
    assign rx_mode    = rx_mode_q;
    assign rx_payload = rx_payload_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
